alu_cmd_issuer: RTL

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_piso_shift.sv | 61 ++++++
 rtl/alu_cmd_issuer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared widths, opcodes and FSM state type for the ALU issuer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int OP_W  = 3;
    localparam int RES_W = 6;
    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] OP_ADD = 2'b00;
    localparam logic [SEL_W-1:0] OP_SUB = 2'b01;
    localparam logic [SEL_W-1:0] OP_MUL = 2'b10;
    localparam logic [SEL_W-1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    function automatic logic is_div0(input logic [SEL_W-1:0] sel, input logic [OP_W-1:0] b);
        return (sel == OP_DIV) && (b == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_piso_shift.sv
`default_nettype none
// ============================================================================
// Module      : alu_piso_shift
// Description : Parallel-load serializer for one ALU result word.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_piso_shift
    import alu_pkg::*;
#(
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [RES_W-1:0] load_data,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last
);

    localparam int                c_cnt_w    = $clog2(RES_W);
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(RES_W - 1);

    logic [RES_W-1:0]   r_data;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_active;
    logic               w_bit;
    logic               w_last;

    assign w_bit  = (MSB_FIRST != 0) ? r_data[RES_W-1] : r_data[0];
    assign w_last = r_active && (r_cnt == c_last_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (load) begin
            r_data   <= load_data;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (shift_en && r_active) begin
            r_data <= (MSB_FIRST != 0) ? {r_data[RES_W-2:0], 1'b0}
                                       : {1'b0, r_data[RES_W-1:1]};
            if (w_last) begin
                r_cnt    <= '0;
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // The serial line is forced low outside the valid window.
    assign ser_out   = r_active & w_bit;
    assign ser_valid = r_active;
    assign ser_last  = w_last;

endmodule
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_issuer
// Description : Drives a combinational ALU, waits for it to settle, captures
//               the result and streams it out serially.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned MSB_FIRST     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_a,
    input  logic [OP_W-1:0]  cmd_b,
    input  logic [SEL_W-1:0] cmd_sel,
    output logic [OP_W-1:0]  alu_a,
    output logic [OP_W-1:0]  alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [RES_W-1:0] alu_result,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy,
    output logic             err_div0
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("alu_cmd_issuer: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0]       c_settle_init = 4'(SETTLE_CYCLES - 1);
    localparam logic [RES_W-1:0] c_div0_fill   = '1;

    state_t           r_state;
    logic [3:0]       r_settle;
    logic [OP_W-1:0]  r_alu_a;
    logic [OP_W-1:0]  r_alu_b;
    logic [SEL_W-1:0] r_alu_sel;
    logic             r_err_div0;

    logic             w_accept;
    logic             w_div0;
    logic             w_capture;
    logic             w_load;
    logic [RES_W-1:0] w_load_data;
    logic             w_shift_en;
    logic             w_ser_last;

    assign w_accept    = cmd_valid && (r_state == ST_IDLE);
    assign w_div0      = is_div0(cmd_sel, cmd_b);
    assign w_capture   = (r_state == ST_DRIVE) && (r_settle == 4'd0);
    // Divide-by-zero bypasses the ALU and streams all ones straight away.
    assign w_load      = (w_accept && w_div0) || w_capture;
    assign w_load_data = w_capture ? alu_result : c_div0_fill;
    assign w_shift_en  = (r_state == ST_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_settle   <= 4'd0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_sel  <= '0;
            r_err_div0 <= 1'b0;
        end else begin
            r_err_div0 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_alu_a   <= cmd_a;
                        r_alu_b   <= cmd_b;
                        r_alu_sel <= cmd_sel;
                        if (w_div0) begin
                            r_state    <= ST_SHIFT;
                            r_err_div0 <= 1'b1;
                        end else begin
                            r_state  <= ST_DRIVE;
                            r_settle <= c_settle_init;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (r_settle == 4'd0) begin
                        r_state <= ST_SHIFT;
                    end else begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                ST_SHIFT: begin
                    if (w_ser_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    alu_piso_shift #(
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .load_data (w_load_data),
        .shift_en  (w_shift_en),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_last  (w_ser_last)
    );

    assign ser_last  = w_ser_last;
    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign err_div0  = r_err_div0;

endmodule
`default_nettype wire
